dsp_mac_sequencer: RTL
======================

Name: dsp_mac_sequencer

Overview:
Initiator-side controller that drives one DSP48A1 slice as a dot-product engine. It accepts a stream of (a,b) operand pairs over a valid/ready handshake and issues them to the slice's A/B ports. It sequences OPMODE and CEP so the slice computes P = sum(a_i*b_i) over cfg_len terms. It then captures P and returns it on a valid/ready result port. It sits between a sample source and the DSP48A1 instance; the slice's A/B/P ports are this block's far end.

Parameters:
LEN_W, 8, width of cfg_len (max terms 2^LEN_W-1)
PIPE_LAT, 3, cycles from A/B issue to updated P visible (slice built with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1); legal >=2

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_len, begins a run (honoured only in IDLE)
cfg_len  in  LEN_W  number of terms for the run
s_valid  in  1  operand pair valid
s_ready  out  1  operand pair accepted when s_valid&s_ready
s_a  in  18  operand a (unsigned)
s_b  in  18  operand b (unsigned)
dsp_a  out  18  to slice A
dsp_b  out  18  to slice B
dsp_opmode  out  8  to slice OPMODE
dsp_cep  out  1  to slice CEP
dsp_p  in  48  from slice P
m_valid  out  1  result valid
m_ready  in  1  result accepted when m_valid&m_ready
m_result  out  48  accumulated dot product
busy  out  1  high in any state but IDLE

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE. All outputs 0, including dsp_a, dsp_b, dsp_opmode=8'h00, dsp_cep, m_valid, m_result and s_ready. The issue pipeline is cleared.
- The slice has CEA/CEB/CEM/CEOPMODE tied 1 and OPMODE[4]=0 (no pre-adder). Only CEP gates accumulation.
- FSM:
  - IDLE: on start, latch remaining=cfg_len. If cfg_len==0, go to HOLD with m_result=0 and issue no DSP activity. Otherwise go to LOAD.
  - LOAD: s_ready=1 while remaining>0. On each handshake in cycle t:
    - drive dsp_a=s_a and dsp_b=s_b (registered, so visible in t+1 as the issue cycle);
    - decrement remaining;
    - push valid=1, plus first=1 if this is the first term of the run, into the issue pipeline.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: s_ready=0. Wait until the issue pipeline is empty, then capture m_result<=dsp_p and go to HOLD.
  - HOLD: m_valid=1 with m_result stable. On m_ready, go to IDLE; m_valid drops the next cycle.
- Issue pipeline: a valid/first delay line indexed from the issue cycle.
  - At stage PIPE_LAT-2, drive dsp_opmode: 8'h01 (X=M, Z=0) if first, else 8'h09 (X=M, Z=P). If the stage is empty, drive 8'h00.
  - At stage PIPE_LAT-1, drive dsp_cep=valid.
- Bubbles (s_valid low) produce no CEP, so P holds. Gaps of any length are legal.
- Arithmetic: products are 36-bit unsigned and the sum wraps modulo 2^48 inside the slice. There is no overflow flag.
- start while busy is ignored. m_result persists after HOLD until the next capture.
- dsp_a and dsp_b hold their last value when no pair is issued.
- Reset mid-run abandons the run immediately. Slice contents are don't-care, because the next run's first term uses Z=0.

Optional Feature:
DSP_MAC_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in any state forces IDLE next cycle and clears the issue pipeline, s_ready, m_valid and dsp_cep. m_result is unchanged. abort takes precedence over start in the same cycle.
- Undefined: no abort port; a run can be ended only by completion or RST_N.

Decomposition:
- Package dsp_mac_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, HOLD};
  - OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_IDLE=8'h00;
  - DSP_W=18, P_W=48.
- One sub-module, dsp_mac_vpipe: parameterised PIPE_LAT shift line carrying {valid, first} with an empty flag, async active-low reset.

Test Plan:
- cfg_len=3, pairs (2,3),(4,5),(6,7) back-to-back, m_ready=1 -> m_result=68, m_valid for 1 cycle, busy low after.
- Same run with s_valid low for 2 cycles between every pair -> m_result=68; dsp_cep pulses exactly 3 times, and dsp_opmode=8'h01 only at the first term.
- Second run cfg_len=1, pair (1,1) right after the first run -> m_result=1, not 69 (first-term Z=0).
- cfg_len=0 start -> m_valid next cycle with m_result=0; dsp_cep never asserted.
- m_ready held low 5 cycles in HOLD -> m_valid and m_result=68 stable; a start pulse during HOLD is ignored.
- RST_N low for 1 cycle mid-LOAD after 1 of 3 pairs -> all outputs 0 immediately; a fresh cfg_len=2 run with (3,3),(1,2) -> 11.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_pkg
// Shared types and constants for the DSP48A1 dot-product sequencer.
//   state_t    : sequencer FSM states
//   OPM_*      : OPMODE encodings driven to the slice (no pre-adder)
//   DSP_W/P_W  : slice A/B operand width and P accumulator width
// -----------------------------------------------------------------------------
package dsp_mac_pkg;

    localparam int DSP_W = 18;
    localparam int P_W   = 48;

    // X = M, Z = 0 : first term of a run discards whatever P held before
    localparam logic [7:0] OPM_FIRST = 8'h01;
    // X = M, Z = P : accumulate
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_mac_vpipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_vpipe
// PIPE_LAT-deep shift line tracking issued terms as they travel through the
// slice registers. Stage 0 is the issue cycle (the cycle dsp_a/dsp_b carry
// the pair).
//   CLK, RST_N  : clock, asynchronous active-low reset
//   clear       : synchronous flush of every stage
//   push_valid  : a term is issued next cycle
//   push_first  : that term is the first of its run
//   valid/first : per-stage flags, index = cycles since issue
//   empty       : no term in flight
// -----------------------------------------------------------------------------
module dsp_mac_vpipe #(
    parameter int PIPE_LAT = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                clear,
    input  logic                push_valid,
    input  logic                push_first,
    output logic [PIPE_LAT-1:0] valid,
    output logic [PIPE_LAT-1:0] first,
    output logic                empty
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= '0;
            first <= '0;
        end else if (clear) begin
            valid <= '0;
            first <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the pre-edge values.
            valid <= {valid[PIPE_LAT-2:0], push_valid};
            first <= {first[PIPE_LAT-2:0], push_valid & push_first};
        end
    end

    assign empty = ~|valid;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Drives one DSP48A1 slice (A1REG/B1REG/MREG/PREG/OPMODEREG = 1) as a
// dot-product engine: P = sum(a_i * b_i) over cfg_len terms, result returned
// on a valid/ready port.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   start, cfg_len      : begin a run of cfg_len terms (IDLE only)
//   s_valid/s_ready/s_a/s_b : operand pair stream
//   dsp_a/dsp_b/dsp_opmode/dsp_cep : to the slice
//   dsp_p               : from the slice
//   m_valid/m_ready/m_result : result stream
//   busy                : not IDLE
//   abort               : only when DSP_MAC_ABORT_EN is defined; returns to
//                         IDLE next cycle and flushes in-flight terms
// Optional feature macro: DSP_MAC_ABORT_EN
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
`ifdef DSP_MAC_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSP_W-1:0] s_a,
    input  logic [DSP_W-1:0] s_b,
    output logic [DSP_W-1:0] dsp_a,
    output logic [DSP_W-1:0] dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cep,
    input  logic [P_W-1:0]   dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_result,
    output logic             busy
);

    state_t             state, next_state;
    logic [LEN_W-1:0]   remaining;
    logic               first_pending;
    logic               hs;
    logic               abort_i;
    logic [PIPE_LAT-1:0] pipe_valid, pipe_first;
    logic               pipe_empty;

`ifdef DSP_MAC_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign hs = s_valid & s_ready;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        next_state = state;
        if (abort_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start) next_state = (cfg_len == '0) ? HOLD : LOAD;
                LOAD:  if (hs && remaining == LEN_W'(1)) next_state = DRAIN;
                // P reflects the last term exactly when nothing is left in flight
                DRAIN: if (pipe_empty) next_state = HOLD;
                HOLD:  if (m_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        s_ready = (state == LOAD) && (remaining != '0);
        m_valid = (state == HOLD);
        busy    = (state != IDLE);
    end

    // Run bookkeeping, operand issue registers and result capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            remaining     <= '0;
            first_pending <= 1'b0;
            dsp_a         <= '0;
            dsp_b         <= '0;
            m_result      <= '0;
        end else begin
            if (state == IDLE && start && !abort_i) begin
                remaining     <= cfg_len;
                first_pending <= 1'b1;
                if (cfg_len == '0) m_result <= '0;
            end
            if (hs) begin
                dsp_a         <= s_a;
                dsp_b         <= s_b;
                remaining     <= remaining - 1'b1;
                first_pending <= 1'b0;
            end
            if (state == DRAIN && pipe_empty && !abort_i) m_result <= dsp_p;
        end
    end

    dsp_mac_vpipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_vpipe (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear      (abort_i),
        .push_valid (hs),
        .push_first (first_pending),
        .valid      (pipe_valid),
        .first      (pipe_first),
        .empty      (pipe_empty)
    );

    // OPMODE is registered in the slice, so it leads CEP by one stage.
    always_comb begin
        dsp_opmode = OPM_IDLE;
        if (pipe_valid[PIPE_LAT-2])
            dsp_opmode = pipe_first[PIPE_LAT-2] ? OPM_FIRST : OPM_ACC;
    end

    assign dsp_cep = pipe_valid[PIPE_LAT-1];

endmodule
